// File: rtl/conv3x3_stream.sv
// conv3x3_stream
// Streaming 3x3 neighbourhood filter. Pixels arrive in raster order over a
// valid/ready handshake; two line buffers plus a 3x3 window give one filtered
// pixel for every interior position, (COLS-2)*(ROWS-2) per frame.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   mod        kernel select, latched on the accept of pixel (0,0)
//              0 pass, 1 gaussian, 2 sobel, 3 laplacian, 4 dilate, 5 erode,
//              6/7 pass
//   in_valid   source has a pixel
//   in_ready   block accepts a pixel this cycle
//   in_data    pixel, row-major, col 0 first
//   out_valid  out_data/out_x/out_y/out_last valid
//   out_ready  sink accepts output
//   out_data   filtered pixel
//   out_x      window centre column (1..COLS-2)
//   out_y      window centre row (1..ROWS-2)
//   out_last   final output of the frame
module conv3x3_stream #(
    parameter int BITWIDTH = 8,
    parameter int COLS     = 6,
    parameter int ROWS     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mod,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITWIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITWIDTH-1:0]   out_data,
    output logic [$clog2(COLS):0] out_x,
    output logic [$clog2(ROWS):0] out_y,
    output logic                  out_last
);
    localparam int CW = $clog2(COLS) + 1;
    localparam int RW = $clog2(ROWS) + 1;
    localparam int IW = $clog2(COLS);
    localparam int W3 = BITWIDTH + 3;
    localparam int W4 = BITWIDTH + 4;

    typedef enum logic [2:0] {
        K_PASS    = 3'd0,
        K_GAUSS   = 3'd1,
        K_SOBEL   = 3'd2,
        K_LAPLACE = 3'd3,
        K_DILATE  = 3'd4,
        K_ERODE   = 3'd5,
        K_RSVD6   = 3'd6,
        K_RSVD7   = 3'd7
    } kernel_t;

    kernel_t        mode_q;
    logic [CW-1:0]  col_cnt;
    logic [RW-1:0]  row_cnt;
    logic [IW-1:0]  col_idx;
    logic           adv;
    logic           accept;
    logic           col_last;
    logic           row_last;

    // S1 bookkeeping travelling alongside the window register
    logic           s1_valid;
    logic [CW-1:0]  s1_x;
    logic [RW-1:0]  s1_y;
    logic           s1_last;

    logic [BITWIDTH-1:0] lb0 [COLS];
    logic [BITWIDTH-1:0] lb1 [COLS];
    logic [BITWIDTH-1:0] win [9];   // row-major, win[4] is the centre

    // The whole pipeline moves only when S2 can take a new value, so a stall
    // freezes counters, line buffers, window and output together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign col_last = (col_cnt == CW'(COLS - 1));
    assign row_last = (row_cnt == RW'(ROWS - 1));
    assign col_idx  = col_cnt[IW-1:0];

    // Line buffers and window carry no reset: a window is consumed only from
    // row 2 onwards, by which point rows 0 and 1 of the frame have overwritten
    // every column that is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_idx] <= lb1[col_idx];
            lb1[col_idx] <= in_data;
            for (int unsigned r = 0; r < 3; r++) begin
                win[r*3]     <= win[r*3 + 1];
                win[r*3 + 1] <= win[r*3 + 2];
            end
            win[2] <= lb0[col_idx];
            win[5] <= lb1[col_idx];
            win[8] <= in_data;
        end
    end

    logic signed [W3-1:0] sx [9];
    logic [W4-1:0]        g_sum;
    logic signed [W3-1:0] gx;
    logic signed [W3-1:0] gy;
    logic signed [W3-1:0] lap;
    logic [W3-1:0]        gx_abs;
    logic [W3-1:0]        gy_abs;
    logic [W3-1:0]        lap_abs;
    logic [W3-1:0]        sob_sum;
    logic [BITWIDTH-1:0]  win_max;
    logic [BITWIDTH-1:0]  win_min;
    logic [BITWIDTH-1:0]  result;

    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            sx[i] = $signed({3'b000, win[i]});
        end

        g_sum = W4'(win[0]) + W4'(win[2]) + W4'(win[6]) + W4'(win[8])
              + ((W4'(win[1]) + W4'(win[3]) + W4'(win[5]) + W4'(win[7])) << 1)
              + (W4'(win[4]) << 2);

        gx  = (sx[2] + (sx[5] <<< 1) + sx[8]) - (sx[0] + (sx[3] <<< 1) + sx[6]);
        gy  = (sx[6] + (sx[7] <<< 1) + sx[8]) - (sx[0] + (sx[1] <<< 1) + sx[2]);
        lap = (sx[4] <<< 2) - sx[1] - sx[3] - sx[5] - sx[7];

        gx_abs  = gx[W3-1]  ? $unsigned(-gx)  : $unsigned(gx);
        gy_abs  = gy[W3-1]  ? $unsigned(-gy)  : $unsigned(gy);
        lap_abs = lap[W3-1] ? $unsigned(-lap) : $unsigned(lap);
        sob_sum = gx_abs + gy_abs;

        win_max = win[0];
        win_min = win[0];
        for (int unsigned i = 1; i < 9; i++) begin
            if (win[i] > win_max) win_max = win[i];
            if (win[i] < win_min) win_min = win[i];
        end

        case (mode_q)
            K_GAUSS:   result = g_sum[W4-1:4];
            K_SOBEL:   result = (|sob_sum[W3-1:BITWIDTH]) ? '1 : sob_sum[BITWIDTH-1:0];
            K_LAPLACE: result = (|lap_abs[W3-1:BITWIDTH]) ? '1 : lap_abs[BITWIDTH-1:0];
            K_DILATE:  result = win_max;
            K_ERODE:   result = win_min;
            default:   result = win[4];
        endcase
    end

    // The last result of a frame reaches S2 no later than the edge that
    // accepts the next (0,0), so it is always computed with the old mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            mode_q    <= K_PASS;
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                out_data <= result;
                out_x    <= s1_x;
                out_y    <= s1_y;
            end

            s1_valid <= accept && (col_cnt >= CW'(2)) && (row_cnt >= RW'(2));
            if (accept) begin
                s1_x    <= col_cnt - CW'(1);
                s1_y    <= row_cnt - RW'(1);
                s1_last <= col_last && row_last;
                if (col_cnt == '0 && row_cnt == '0) begin
                    mode_q <= kernel_t'(mod);
                end
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream (6x6 frames, 8-bit pixels).
module tb_conv3x3_stream;
    localparam int B = 8;
    localparam int C = 6;
    localparam int R = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] mod = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic       out_last;

    conv3x3_stream #(.BITWIDTH(B), .COLS(C), .ROWS(R)) dut (
        .clk(clk), .rst(rst), .mod(mod),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // pat: 0 constant 100, 1 vertical edge (cols 3-5 = 255), 2 impulse 255 at (2,2)
    typedef struct packed {
        logic [2:0]        mod;
        logic [1:0]        pat;
        logic [0:15][7:0]  exp;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] m;
    } pix_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] x;
        logic [3:0] y;
        logic       last;
        int         tag;
        int         k;
    } out_t;

    vec_t  tbl [14];
    pix_t  in_q [$];
    out_t  exp_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [7:0] pix(input logic [1:0] pat, input int c, input int r);
        case (pat)
            2'd0:    return 8'd100;
            2'd1:    return (c >= 3) ? 8'd255 : 8'd0;
            default: return (c == 2 && r == 2) ? 8'd255 : 8'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add_frame(input logic [1:0] pat, input logic [2:0] m, input logic [2:0] m2,
                             input int switch_at, input int npix);
        pix_t p;
        for (int i = 0; i < npix; i++) begin
            p.d = pix(pat, i % C, i / C);
            p.m = (i < switch_at) ? m : m2;
            in_q.push_back(p);
        end
    endtask

    task automatic add_exp(input logic [0:15][7:0] e, input int tag, input int n);
        out_t o;
        for (int k = 0; k < n; k++) begin
            o.d    = e[k];
            o.x    = 4'(k % 4 + 1);
            o.y    = 4'(k / 4 + 1);
            o.last = (k == 15);
            o.tag  = tag;
            o.k    = k;
            exp_q.push_back(o);
        end
    endtask

    task automatic check_reset_state(input string name);
        check(name, 32'({out_valid, in_ready, out_data, out_x, out_y, out_last}),
              32'({1'b0, 1'b1, 8'd0, 4'd0, 4'd0, 1'b0}));
    endtask

    task automatic run_stream(input bit bp, input int budget);
        int in_idx  = 0;
        int out_idx = 0;
        int cyc     = 0;
        while ((in_idx < in_q.size() || out_idx < exp_q.size()) && cyc < budget) begin
            @(negedge clk);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_idx < in_q.size()) begin
                in_valid = 1'b1;
                in_data  = in_q[in_idx].d;
                mod      = in_q[in_idx].m;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (bp) check("in_ready under stall", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (out_idx < exp_q.size()) begin
                    out_t e;
                    e = exp_q[out_idx];
                    check($sformatf("data t%0d k%0d", e.tag, e.k), 32'(out_data), 32'(e.d));
                    check($sformatf("x t%0d k%0d", e.tag, e.k), 32'(out_x), 32'(e.x));
                    check($sformatf("y t%0d k%0d", e.tag, e.k), 32'(out_y), 32'(e.y));
                    check($sformatf("last t%0d k%0d", e.tag, e.k), 32'(out_last), 32'(e.last));
                end else begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra output: got output #%0d, expected only %0d", out_idx, exp_q.size());
                end
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            cyc++;
        end
        if (cyc >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d/%0d outputs, %0d/%0d inputs, expected all",
                     out_idx, exp_q.size(), in_idx, in_q.size());
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("idle after stream", 32'(out_valid), 32'd0);
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        // reset and idle
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("state in reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check_reset_state($sformatf("idle cycle %0d", i));
        end

        // back-to-back frames, one table row per frame
        tbl[0]  = {3'd0, 2'd0, {16{8'd100}}};
        tbl[1]  = {3'd1, 2'd0, {16{8'd100}}};
        tbl[2]  = {3'd2, 2'd0, {16{8'd0}}};
        tbl[3]  = {3'd3, 2'd0, {16{8'd0}}};
        tbl[4]  = {3'd4, 2'd0, {16{8'd100}}};
        tbl[5]  = {3'd5, 2'd0, {16{8'd100}}};
        tbl[6]  = {3'd2, 2'd1, {4{8'd0, 8'd255, 8'd255, 8'd0}}};
        tbl[7]  = {3'd0, 2'd1, {4{8'd0, 8'd0, 8'd255, 8'd255}}};
        tbl[8]  = {3'd1, 2'd1, {4{8'd0, 8'd63, 8'd191, 8'd255}}};
        tbl[9]  = {3'd3, 2'd1, {4{8'd0, 8'd255, 8'd255, 8'd0}}};
        tbl[10] = {3'd3, 2'd2, {8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0,
                                8'd0, 8'd255, 8'd0, 8'd0, {4{8'd0}}}};
        tbl[11] = {3'd1, 2'd2, {8'd15, 8'd31, 8'd15, 8'd0, 8'd31, 8'd63, 8'd31, 8'd0,
                                8'd15, 8'd31, 8'd15, 8'd0, {4{8'd0}}}};
        tbl[12] = {3'd4, 2'd2, {{3{8'd255, 8'd255, 8'd255, 8'd0}}, {4{8'd0}}}};
        tbl[13] = {3'd6, 2'd0, {16{8'd100}}};
        for (int i = 0; i < 14; i++) begin
            add_frame(tbl[i].pat, tbl[i].mod, tbl[i].mod, C * R, C * R);
            add_exp(tbl[i].exp, i, 16);
        end
        run_stream(1'b0, 3000);

        // random back-pressure, constant 100 in gaussian mode
        add_frame(2'd0, 3'd1, 3'd1, C * R, C * R);
        add_exp({16{8'd100}}, 100, 16);
        run_stream(1'b1, 2000);

        // mod changes mid-frame: frame stays gaussian; next frame picks up sobel
        add_frame(2'd2, 3'd1, 3'd2, 10, C * R);
        add_exp({8'd15, 8'd31, 8'd15, 8'd0, 8'd31, 8'd63, 8'd31, 8'd0,
                 8'd15, 8'd31, 8'd15, 8'd0, {4{8'd0}}}, 200, 16);
        add_frame(2'd2, 3'd2, 3'd2, C * R, 20);
        add_exp({8'd255, 8'd255, 8'd255, 8'd0, {12{8'd0}}}, 201, 4);
        run_stream(1'b0, 1000);

        // reset in the middle of that partial frame
        rst = 1'b0;
        #1;
        check_reset_state("async reset mid-frame");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("after mid-frame reset");

        // fresh frame must start at (0,0)
        add_frame(2'd1, 3'd0, 3'd0, C * R, C * R);
        add_exp({4{8'd0, 8'd0, 8'd255, 8'd255}}, 300, 16);
        run_stream(1'b0, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 neighbourhood filter for the PE image pipeline: accepts one raster-order pixel per clock over a valid/ready handshake, holds two line buffers plus a 3x3 window, and emits one filtered pixel per interior position, (COLS-2)*(ROWS-2) per frame. It is the parametrised successor of the fixed-mode filter. Differences: single clock instead of bit-serial fast clock, six selectable kernels, output back-pressure, saturating arithmetic, and a frame-end flag. It sits between the pixel ROM/DMA source and the result RAM writer.

## Interface
- BITWIDTH, 8, pixel width (unsigned)
- COLS, 6, frame width in pixels (>=3)
- ROWS, 6, frame height in pixels (>=3)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- mod  in  3  kernel select; sampled at frame start
- in_valid  in  1  source has a pixel
- in_ready  out  1  block accepts a pixel this cycle
- in_data  in  BITWIDTH  pixel, raster order (row-major, col 0 first)
- out_valid  out  1  out_data/out_x/out_y/out_last valid
- out_ready  in  1  sink accepts output
- out_data  out  BITWIDTH  filtered pixel
- out_x  out  clog2(COLS)+1  centre column of the window (1..COLS-2)
- out_y  out  clog2(ROWS)+1  centre row of the window (1..ROWS-2)
- out_last  out  1  high with the final output of a frame, (COLS-2,ROWS-2)

## Operation
- Accept = in_valid && in_ready. Each accept advances the input column counter (0..COLS-1) and, on wrap, the row counter (0..ROWS-1). Both wrap to 0 after the last pixel of the frame, and the next frame follows with no gap.
- On each accept the pixel is written to line buffer 1. Line buffer 1 feeds line buffer 0. The window shifts left by one column, loading the new column {lb0, lb1, in_data} as rows {top, mid, bottom}.
- Window p[r][c], r,c in 0..2, centre p[1][1]. A result is produced for every accept with col>=2 and row>=2. Its centre is (col-1,row-1).
- mod is latched into an internal register on the accept of pixel (0,0). Changes to mod at any other time take effect next frame.
- Kernels (all intermediate widths sized so nothing overflows before saturation):
  - 0 passthrough: p[1][1].
  - 1 Gaussian: (p00+p02+p20+p22 + 2*(p01+p10+p12+p21) + 4*p11) >> 4. Truncating; width BITWIDTH+4.
  - 2 Sobel: |Gx|+|Gy|, saturated to 2^BITWIDTH-1. Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02); signed, width BITWIDTH+3.
  - 3 Laplacian: |4*p11 - p01 - p10 - p12 - p21|, saturated.
  - 4 dilate: max of 9. 5 erode: min of 9.
  - 6, 7: treated as 0.
- Pipeline: stage S1 = window register; stage S2 = output register (data, x, y, last, valid).
- Stall: adv = !out_valid || out_ready. in_ready = adv. When adv=0, the counters, line buffers, window and S2 all hold.
- The line buffers need no reset. A window is only consumed once rows 0..2 have been filled in the current frame.

## Timing
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, out_x=0, out_y=0, out_last=0, in_ready=1, counters=0, latched mode=0.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (0,0).
- Latency: pixel (c,r), c>=2 and r>=2, accepted at edge N → its result is registered at edge N+1 → out_valid is high from edge N+1 until the edge where out_ready=1.
- Throughput: 1 output/clk while in_valid=1 and out_ready=1. Per frame there are (COLS-2)*(ROWS-2) valid beats and no bubbles except the border positions.
- out_valid drops at the handshake edge unless a new result is registered at the same edge. Data is stable while out_valid && !out_ready.
- out_last is high only together with out_valid on position (COLS-2,ROWS-2).
- Frame wrap and S2 handshake may occur on the same edge; both are honoured.

## Test plan
- Reset/idle: rst low then high, in_valid=0 → out_valid=0, in_ready=1, all outputs 0 for 20 clk.
- Constant frame of 100, 6x6, out_ready=1, each mod 0-5 in successive frames → 16 outputs per frame. All outputs are 100 for mods 0, 1, 4, 5; all are 0 for mods 2, 3. out_x/out_y step (1,1)..(4,4), out_last on the 16th output only.
- Vertical edge (cols 0-2 = 0, cols 3-5 = 255), mod=2 → outputs at x=2,3 equal 255 (saturated from 1020); outputs at x=1,4 equal 0.
- Single impulse 255 at (2,2), mod=3 → output at (2,2)=255 (saturated from 1020); (1,2), (3,2), (2,1), (2,3) = 255; all others 0.
- Back-pressure: toggle out_ready pseudo-randomly on the constant-100/mod 1 frame → no loss or duplication, 16 outputs, in_ready=0 exactly while out_valid && !out_ready.
- mod switched 1→2 mid-frame, then reset asserted mid-frame → the current frame finishes in mod 1. After reset, first accepted pixel restarts at (0,0), mode=0, out_valid=0.
